line_sched: RTL and testbench
=============================

LINE_SCHED -- requirements
Module: line_sched

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req0_valid, req1_valid  input  1 each  requester has a line descriptor.
REQ-004 SHALL have ports req0_line, req1_line  input  43 each  {x0[42:33], y0[32:23], x1[22:13], y1[12:3], color[2:0]}.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  descriptor accepted this cycle.
REQ-006 SHALL have port flush  input  1  synchronous abort to IDLE.
REQ-007 SHALL have port lg_done  input  1  line generator finished its last point (one-cycle pulse).
REQ-008 SHALL have ports lg_x0, lg_y0, lg_x1, lg_y1  output  10 each  normalized endpoints to the line generator.
REQ-009 SHALL have port lg_dy  output  11  signed y1-y0 after normalization.
REQ-010 SHALL have port lg_p_or_n  output  1  1 = y non-decreasing along line.
REQ-011 SHALL have port lg_color  output  3  pixel color.
REQ-012 SHALL have port lg_line_available  output  1  descriptor valid for generator, one-cycle pulse.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port last_grant  output  1  requester index of most recent accept.
REQ-015 SHALL have port lines_done  output  16  count of completed lines.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ISSUE -> WAIT -> IDLE.
REQ-017 IDLE: grant when any valid; accept = readyN & validN; next state SETUP; else stay IDLE.
REQ-018 readyN SHALL be combinational, high only in IDLE, for the granted requester, with flush low; never both high.
REQ-019 Arbitration SHALL be round-robin: single valid wins; both valid -> the requester not equal to last_grant wins.
REQ-020 On accept, SHALL latch the descriptor and set last_grant to the winner index.
REQ-021 SETUP: if x0 > x1, SHALL swap (x0,y0) with (x1,y1); x0 == x1 keeps order.
REQ-022 SETUP: SHALL compute lg_dy = {1'b0,y1} - {1'b0,y0} (11-bit two's complement) and lg_p_or_n = (y1 >= y0).
REQ-023 ISSUE: lg_line_available SHALL be high for exactly this one cycle; next state WAIT.
REQ-024 lg_x0..lg_color, lg_dy, lg_p_or_n SHALL be registered and held stable from ISSUE until the next SETUP.
REQ-025 WAIT: on lg_done, SHALL go to IDLE and increment lines_done; otherwise stay in WAIT.
REQ-026 lg_done outside WAIT SHALL be ignored.
REQ-027 lines_done SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 Latency: accept in cycle N; lg_line_available in cycle N+2; earliest next accept is the cycle after the lg_done cycle.
REQ-029 flush high in any state SHALL force IDLE next cycle, without incrementing lines_done and without asserting lg_line_available or ready; flush has priority over lg_done.
REQ-030 The degenerate line x0==x1 and y0==y1 SHALL be issued normally (dy=0, p_or_n=1).

Reset
REQ-031 On rst low, the block SHALL enter IDLE immediately, regardless of clk.
REQ-032 On rst low, all lg_* outputs, busy, last_grant and lines_done SHALL be 0.
REQ-033 last_grant reset value 0 SHALL cause req1 to win the first two-way contention.
REQ-034 Reset asserted mid-line SHALL discard the latched descriptor.

Verification
REQ-035 req0 (x0=100,y0=50,x1=20,y1=80,c=5) -> req0_ready pulse; 2 cycles later lg_line_available=1; lg=(20,80,100,50), dy=-30 (11'h7E2), p_or_n=0, color=5.
REQ-036 Both valid from reset, lg_done after each line -> grants 1,0,1,0; readyN never both high; lines_done=4.
REQ-037 req1 (5,5,5,300) -> no swap, dy=295, p_or_n=1; lg_done pulsed in IDLE/SETUP is ignored; only the WAIT pulse counts.
REQ-038 Assert flush during WAIT together with lg_done -> IDLE next cycle; lines_done unchanged; the queued req accepted the following cycle.
REQ-039 Preload lines_done=16'hFFFF (via 65535 lines or a force) -> one more lg_done -> 16'h0000.
REQ-040 rst low during WAIT -> all outputs 0 asynchronously; after release, IDLE with no spurious lg_line_available.

Source files
------------

// File: rtl/line_sched_if.sv
// Requester and line-generator handshake bundle for line_sched.
interface line_sched_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [42:0] req0_line;
    logic [42:0] req1_line;
    logic        req0_ready;
    logic        req1_ready;
    logic        lg_done;
    logic [9:0]  lg_x0;
    logic [9:0]  lg_y0;
    logic [9:0]  lg_x1;
    logic [9:0]  lg_y1;
    logic [10:0] lg_dy;
    logic        lg_p_or_n;
    logic [2:0]  lg_color;
    logic        lg_line_available;

    // Requesters and the line generator drive this side.
    modport master (
        output req0_valid, req1_valid, req0_line, req1_line, lg_done,
        input  req0_ready, req1_ready, lg_x0, lg_y0, lg_x1, lg_y1, lg_dy, lg_p_or_n,
               lg_color, lg_line_available
    );

    // The scheduler sits on this side.
    modport slave (
        input  req0_valid, req1_valid, req0_line, req1_line, lg_done,
        output req0_ready, req1_ready, lg_x0, lg_y0, lg_x1, lg_y1, lg_dy, lg_p_or_n,
               lg_color, lg_line_available
    );
endinterface

// File: rtl/line_sched.sv
// Two-requester round-robin line scheduler: accepts a line descriptor, normalizes it
// so x0 <= x1, hands it to the line generator and waits for completion.
module line_sched (
    input  logic          clk,
    input  logic          rst,
    line_sched_if.slave   bus,
    input  logic          flush,
    output logic          busy,
    output logic          last_grant,
    output logic [15:0]   lines_done
);

    typedef enum logic [1:0] {StIdle, StSetup, StIssue, StWait} state_e;

    state_e      state_q, state_d;
    logic        grant_sel;
    logic        ready0, ready1, accept;
    logic        lines_inc;
    logic        last_grant_q;
    logic [15:0] lines_done_q;
    logic [42:0] desc_q;

    logic [9:0]  d_x0, d_y0, d_x1, d_y1;
    logic        swap;
    logic [9:0]  n_x0, n_y0, n_x1, n_y1;
    logic [10:0] n_dy;

    logic [9:0]  lg_x0_q, lg_y0_q, lg_x1_q, lg_y1_q;
    logic [10:0] lg_dy_q;
    logic        lg_p_or_n_q;
    logic [2:0]  lg_color_q;

    // Round-robin pick: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        grant_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_sel = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_sel = 1'b1;
        end
        ready0 = (state_q == StIdle) && !flush && bus.req0_valid && !grant_sel;
        ready1 = (state_q == StIdle) && !flush && bus.req1_valid && grant_sel;
        accept = ready0 | ready1;
    end

    // Next-state logic; flush overrides everything, including a same-cycle lg_done.
    always_comb begin
        state_d   = state_q;
        lines_inc = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = StSetup;
                StSetup: state_d = StIssue;
                StIssue: state_d = StWait;
                StWait: begin
                    if (bus.lg_done) begin
                        state_d   = StIdle;
                        lines_inc = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Endpoint normalization: order by x so the generator always walks left to right.
    always_comb begin
        d_x0 = desc_q[42:33];
        d_y0 = desc_q[32:23];
        d_x1 = desc_q[22:13];
        d_y1 = desc_q[12:3];
        swap = d_x0 > d_x1;
        n_x0 = swap ? d_x1 : d_x0;
        n_y0 = swap ? d_y1 : d_y0;
        n_x1 = swap ? d_x0 : d_x1;
        n_y1 = swap ? d_y0 : d_y1;
        n_dy = {1'b0, n_y1} - {1'b0, n_y0};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Descriptor capture, grant history and completion counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desc_q       <= '0;
            last_grant_q <= 1'b0;
            lines_done_q <= '0;
        end else begin
            if (accept) begin
                desc_q       <= grant_sel ? bus.req1_line : bus.req0_line;
                last_grant_q <= grant_sel;
            end
            if (lines_inc) begin
                lines_done_q <= lines_done_q + 16'd1;
            end
        end
    end

    // Generator outputs load at the end of SETUP and hold until the next SETUP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lg_x0_q     <= '0;
            lg_y0_q     <= '0;
            lg_x1_q     <= '0;
            lg_y1_q     <= '0;
            lg_dy_q     <= '0;
            lg_p_or_n_q <= 1'b0;
            lg_color_q  <= '0;
        end else if (state_q == StSetup && !flush) begin
            lg_x0_q     <= n_x0;
            lg_y0_q     <= n_y0;
            lg_x1_q     <= n_x1;
            lg_y1_q     <= n_y1;
            lg_dy_q     <= n_dy;
            lg_p_or_n_q <= (n_y1 >= n_y0);
            lg_color_q  <= desc_q[2:0];
        end
    end

    // Output drive.
    always_comb begin
        bus.req0_ready        = ready0;
        bus.req1_ready        = ready1;
        bus.lg_x0             = lg_x0_q;
        bus.lg_y0             = lg_y0_q;
        bus.lg_x1             = lg_x1_q;
        bus.lg_y1             = lg_y1_q;
        bus.lg_dy             = lg_dy_q;
        bus.lg_p_or_n         = lg_p_or_n_q;
        bus.lg_color          = lg_color_q;
        bus.lg_line_available = (state_q == StIssue) && !flush;
        busy                  = (state_q != StIdle);
        last_grant            = last_grant_q;
        lines_done            = lines_done_q;
    end

endmodule

// File: tb/tb_line_sched.sv
// Directed bench for line_sched: reset, swap, round-robin, done filtering, flush,
// counter wrap and mid-line reset.
module tb_line_sched;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        busy;
    logic        last_grant;
    logic [15:0] lines_done;
    int          n_run;
    int          n_fail;

    line_sched_if bus ();

    line_sched dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .flush      (flush),
        .busy       (busy),
        .last_grant (last_grant),
        .lines_done (lines_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [42:0] mk_line(input logic [9:0] x0, input logic [9:0] y0,
                                            input logic [9:0] x1, input logic [9:0] y1,
                                            input logic [2:0] c);
        return {x0, y0, x1, y1, c};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_run++; if (last_grant !== 1'b0) begin n_fail++; $display("FAIL rst_last_grant: got %b want 0", last_grant); end
        n_run++; if (lines_done !== 16'h0) begin n_fail++; $display("FAIL rst_lines_done: got %h want 0", lines_done); end
        n_run++; if ({bus.lg_x0, bus.lg_y0, bus.lg_x1, bus.lg_y1, bus.lg_dy, bus.lg_p_or_n, bus.lg_color, bus.lg_line_available} !== '0)
            begin n_fail++; $display("FAIL rst_lg_outputs: got nonzero x0=%h dy=%h lav=%b want all 0", bus.lg_x0, bus.lg_dy, bus.lg_line_available); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_swap();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_line  = mk_line(10'd100, 10'd50, 10'd20, 10'd80, 3'd5);
        #1;
        n_run++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            begin n_fail++; $display("FAIL swap_ready: got r0=%b r1=%b want r0=1 r1=0", bus.req0_ready, bus.req1_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        n_run++; if (bus.lg_line_available !== 1'b0) begin n_fail++; $display("FAIL swap_lav_setup: got %b want 0", bus.lg_line_available); end
        @(negedge clk);
        #1;
        n_run++; if (bus.lg_line_available !== 1'b1) begin n_fail++; $display("FAIL swap_lav_issue: got %b want 1", bus.lg_line_available); end
        n_run++; if ({bus.lg_x0, bus.lg_y0, bus.lg_x1, bus.lg_y1} !== {10'd20, 10'd80, 10'd100, 10'd50})
            begin n_fail++; $display("FAIL swap_endpoints: got %0d,%0d,%0d,%0d want 20,80,100,50", bus.lg_x0, bus.lg_y0, bus.lg_x1, bus.lg_y1); end
        n_run++; if (bus.lg_dy !== 11'h7E2 || bus.lg_p_or_n !== 1'b0 || bus.lg_color !== 3'd5)
            begin n_fail++; $display("FAIL swap_dy_pn_color: got dy=%h pn=%b c=%0d want 7e2 0 5", bus.lg_dy, bus.lg_p_or_n, bus.lg_color); end
        @(negedge clk);
        #1;
        n_run++; if (bus.lg_line_available !== 1'b0 || busy !== 1'b1 || bus.lg_x0 !== 10'd20)
            begin n_fail++; $display("FAIL swap_wait_hold: got lav=%b busy=%b x0=%0d want 0 1 20", bus.lg_line_available, busy, bus.lg_x0); end
        bus.lg_done = 1'b1;
        @(negedge clk);
        bus.lg_done = 1'b0;
        #1;
        n_run++; if (busy !== 1'b0 || lines_done !== 16'd1)
            begin n_fail++; $display("FAIL swap_done: got busy=%b lines=%0d want 0 1", busy, lines_done); end
    endtask

    task automatic test_rr();
        logic exp_g;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_line  = mk_line(10'd1, 10'd2, 10'd3, 10'd4, 3'd1);
        bus.req1_line  = mk_line(10'd5, 10'd6, 10'd7, 10'd8, 3'd2);
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0);
            #1;
            n_run++; if (bus.req1_ready !== exp_g || bus.req0_ready !== !exp_g)
                begin n_fail++; $display("FAIL rr_grant%0d: got r0=%b r1=%b want r1=%b", i, bus.req0_ready, bus.req1_ready, exp_g); end
            @(negedge clk);
            #1;
            n_run++; if (last_grant !== exp_g || (bus.req0_ready && bus.req1_ready))
                begin n_fail++; $display("FAIL rr_last%0d: got lg=%b r0=%b r1=%b want lg=%b", i, last_grant, bus.req0_ready, bus.req1_ready, exp_g); end
            @(negedge clk);
            @(negedge clk);
            bus.lg_done = 1'b1;
            @(negedge clk);
            bus.lg_done = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        n_run++; if (lines_done !== 16'd4) begin n_fail++; $display("FAIL rr_lines_done: got %0d want 4", lines_done); end
    endtask

    task automatic test_no_swap();
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_line  = mk_line(10'd5, 10'd5, 10'd5, 10'd300, 3'd3);
        bus.lg_done    = 1'b1;
        #1;
        n_run++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0)
            begin n_fail++; $display("FAIL ns_ready: got r0=%b r1=%b want 0 1", bus.req0_ready, bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        bus.lg_done = 1'b0;
        #1;
        n_run++; if ({bus.lg_x0, bus.lg_y0, bus.lg_x1, bus.lg_y1} !== {10'd5, 10'd5, 10'd5, 10'd300})
            begin n_fail++; $display("FAIL ns_endpoints: got %0d,%0d,%0d,%0d want 5,5,5,300", bus.lg_x0, bus.lg_y0, bus.lg_x1, bus.lg_y1); end
        n_run++; if (bus.lg_dy !== 11'd295 || bus.lg_p_or_n !== 1'b1 || bus.lg_line_available !== 1'b1)
            begin n_fail++; $display("FAIL ns_dy: got dy=%0d pn=%b lav=%b want 295 1 1", bus.lg_dy, bus.lg_p_or_n, bus.lg_line_available); end
        @(negedge clk);
        #1;
        n_run++; if (lines_done !== 16'd4 || busy !== 1'b1)
            begin n_fail++; $display("FAIL ns_ignore_done: got lines=%0d busy=%b want 4 1", lines_done, busy); end
        bus.lg_done = 1'b1;
        @(negedge clk);
        bus.lg_done = 1'b0;
        #1;
        n_run++; if (lines_done !== 16'd5 || busy !== 1'b0 || last_grant !== 1'b1)
            begin n_fail++; $display("FAIL ns_done: got lines=%0d busy=%b lg=%b want 5 0 1", lines_done, busy, last_grant); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_line  = mk_line(10'd30, 10'd40, 10'd60, 10'd10, 3'd4);
        #1;
        n_run++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL fl_accept: got %b want 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.req1_line  = mk_line(10'd9, 10'd9, 10'd1, 10'd1, 3'd6);
        flush          = 1'b1;
        bus.lg_done    = 1'b1;
        #1;
        n_run++; if (bus.req1_ready !== 1'b0 || bus.lg_line_available !== 1'b0)
            begin n_fail++; $display("FAIL fl_wait: got r1=%b lav=%b want 0 0", bus.req1_ready, bus.lg_line_available); end
        @(negedge clk);
        flush       = 1'b0;
        bus.lg_done = 1'b0;
        #1;
        n_run++; if (busy !== 1'b0 || lines_done !== 16'd5 || bus.req1_ready !== 1'b1)
            begin n_fail++; $display("FAIL fl_idle: got busy=%b lines=%0d r1=%b want 0 5 1", busy, lines_done, bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        flush          = 1'b1;
        #1;
        n_run++; if (bus.lg_line_available !== 1'b0 || busy !== 1'b1)
            begin n_fail++; $display("FAIL fl_setup: got lav=%b busy=%b want 0 1", bus.lg_line_available, busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_run++; if (busy !== 1'b0 || bus.lg_line_available !== 1'b0 || lines_done !== 16'd5)
            begin n_fail++; $display("FAIL fl_after: got busy=%b lav=%b lines=%0d want 0 0 5", busy, bus.lg_line_available, lines_done); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.lines_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.lines_done_q;
        #1;
        n_run++; if (lines_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", lines_done); end
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_line  = mk_line(10'd0, 10'd0, 10'd1, 10'd1, 3'd7);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.lg_done = 1'b1;
        @(negedge clk);
        bus.lg_done = 1'b0;
        #1;
        n_run++; if (lines_done !== 16'h0000 || busy !== 1'b0)
            begin n_fail++; $display("FAIL wrap_zero: got lines=%h busy=%b want 0000 0", lines_done, busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_line  = mk_line(10'd7, 10'd9, 10'd7, 10'd9, 3'd2);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_run++; if (bus.lg_dy !== 11'd0 || bus.lg_p_or_n !== 1'b1 || bus.lg_line_available !== 1'b1 ||
                     bus.lg_x0 !== 10'd7 || bus.lg_y1 !== 10'd9)
            begin n_fail++; $display("FAIL degen: got dy=%0d pn=%b lav=%b x0=%0d y1=%0d want 0 1 1 7 9", bus.lg_dy, bus.lg_p_or_n, bus.lg_line_available, bus.lg_x0, bus.lg_y1); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_run++; if (busy !== 1'b0 || last_grant !== 1'b0 || lines_done !== 16'h0 ||
                     {bus.lg_x0, bus.lg_y0, bus.lg_x1, bus.lg_y1, bus.lg_dy, bus.lg_p_or_n, bus.lg_color, bus.lg_line_available} !== '0)
            begin n_fail++; $display("FAIL midrst_async: got busy=%b lg=%b lines=%h x0=%0d lav=%b want all 0", busy, last_grant, lines_done, bus.lg_x0, bus.lg_line_available); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_run++; if (bus.lg_line_available !== 1'b0 || busy !== 1'b0)
                begin n_fail++; $display("FAIL midrst_quiet%0d: got lav=%b busy=%b want 0 0", i, bus.lg_line_available, busy); end
        end
    endtask

    initial begin
        n_run          = 0;
        n_fail         = 0;
        rst            = 1'b0;
        flush          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_line  = '0;
        bus.req1_line  = '0;
        bus.lg_done    = 1'b0;
        test_reset();
        test_swap();
        test_rr();
        test_no_swap();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
